// File: rtl/sevseg_pkg.sv
// Shared types, segment encodings and helpers for the scanned 7-segment display.
// Segment vectors are active-low and ordered g..a (bit 6 = g, bit 0 = a).
package sevseg_pkg;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} sevseg_state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [31:0] pow10(input int unsigned n);
    logic [31:0] p;
    p = 32'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle.
// start loads the operand; done pulses during the final iteration cycle.
module bin_to_bcd_seq
  import sevseg_pkg::*;
#(
  parameter int unsigned VALUE_W = 14,
  parameter int unsigned DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [VALUE_W-1:0]    bin,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd
);

  localparam int unsigned BCD_W = DIGITS * 4;
  localparam int unsigned CNT_W = $clog2(VALUE_W + 1);

  logic [VALUE_W-1:0]       bin_q, bin_d;
  logic [BCD_W-1:0]         bcd_q, bcd_d;
  logic [CNT_W-1:0]         cnt_q;
  logic                     busy_q;
  logic [BCD_W-1:0]         adj;
  logic [BCD_W+VALUE_W-1:0] sh;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i+:4] >= 4'd5) adj[4*i+:4] = bcd_q[4*i+:4] + 4'd3;
    end
    // Bits shifted out above the top nibble are intentionally lost.
    sh    = {adj, bin_q} << 1;
    bcd_d = sh[BCD_W+VALUE_W-1:VALUE_W];
    bin_d = sh[VALUE_W-1:0];
  end

  assign done = busy_q && (cnt_q == CNT_W'(VALUE_W - 1));
  assign busy = busy_q;
  assign bcd  = bcd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      bin_q  <= bin;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/sevseg_scan_display.sv
// Multi-digit scanned 7-segment driver with handshake load and sequential BCD conversion.
// Define SEVSEG_BLANK_LEADING_ZEROS_EN to blank leading zero digits (digit 0 always shown).
module sevseg_scan_display
  import sevseg_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned VALUE_W     = 14,
  parameter int unsigned REFRESH_DIV = 10000
) (
  input  logic                sysclk,
  input  logic                rst,
  input  logic [VALUE_W-1:0]  value,
  input  logic [DIGITS-1:0]   dot_pattern,
  input  logic                load_valid,
  output logic                load_ready,
  output logic [7:0]          segments,
  output logic [DIGITS-1:0]   digit_disable,
  output logic                overflow
);

  localparam int unsigned BCD_W     = DIGITS * 4;
  localparam int unsigned IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PRE_W     = $clog2(REFRESH_DIV);
  localparam logic [31:0] OVF_LIMIT = pow10(DIGITS);

  sevseg_state_t     state_q, state_d;
  logic              start, conv_busy, conv_done;
  logic [BCD_W-1:0]  conv_bcd;
  logic [DIGITS-1:0] dots_q;
  logic              ovf_q;
  logic [BCD_W-1:0]  disp_bcd_q;
  logic [DIGITS-1:0] disp_dots_q;
  logic              disp_ovf_q;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic              tick;
  logic [IDX_W-1:0]  scan_q, scan_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] dis_q, dis_d;
  logic [6:0]        digit_seg [DIGITS];
  logic [DIGITS-1:0] blank;
`ifdef SEVSEG_BLANK_LEADING_ZEROS_EN
  logic              lead_zero;
`endif

  bin_to_bcd_seq #(
    .VALUE_W (VALUE_W),
    .DIGITS  (DIGITS)
  ) u_bin_to_bcd (
    .clk   (sysclk),
    .rst   (rst),
    .start (start),
    .bin   (value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Held low for the whole reset window, not just until the first edge.
  assign load_ready = (state_q == IDLE) && !conv_busy && !rst;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_valid && load_ready) begin
          start   = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: if (conv_done) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dots_q      <= '0;
      ovf_q       <= 1'b0;
      disp_bcd_q  <= '0;
      disp_dots_q <= '0;
      disp_ovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        dots_q <= dot_pattern;
        ovf_q  <= 32'(value) >= OVF_LIMIT;
      end
      if (state_q == COMMIT) begin
        disp_bcd_q  <= conv_bcd;
        disp_dots_q <= dots_q;
        disp_ovf_q  <= ovf_q;
      end
    end
  end

  always_comb begin
    blank = '0;
`ifdef SEVSEG_BLANK_LEADING_ZEROS_EN
    lead_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      lead_zero = lead_zero && (disp_bcd_q[4*i+:4] == 4'd0);
      blank[i]  = lead_zero;
    end
`endif
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (disp_ovf_q)    digit_seg[i] = SEG_DASH;
      else if (blank[i]) digit_seg[i] = SEG_BLANK;
      else               digit_seg[i] = bcd_to_seg(disp_bcd_q[4*i+:4]);
    end
  end

  always_comb begin
    tick    = (presc_q == PRE_W'(REFRESH_DIV - 1));
    presc_d = tick ? '0 : presc_q + PRE_W'(1);
    scan_d  = scan_q;
    seg_d   = seg_q;
    dis_d   = dis_q;
    if (tick) begin
      scan_d = (scan_q == IDX_W'(DIGITS - 1)) ? '0 : scan_q + IDX_W'(1);
      dis_d  = ~(DIGITS'(1) << scan_d);
      seg_d  = {~disp_dots_q[scan_d], digit_seg[scan_d]};
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      scan_q  <= '0;
      seg_q   <= 8'hFF;
      dis_q   <= '1;
    end else begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
      seg_q   <= seg_d;
      dis_q   <= dis_d;
    end
  end

  assign segments      = seg_q;
  assign digit_disable = dis_q;
  assign overflow      = disp_ovf_q;

endmodule

// File: tb/tb_sevseg_scan_display.sv
// Self-checking bench for sevseg_scan_display: directed and random loads against a decimal model.
module tb_sevseg_scan_display;

  localparam int DIGITS  = 4;
  localparam int VALUE_W = 14;
  localparam int REF     = 4;
  localparam int LIMIT   = 10000;

  logic               sysclk = 1'b0;
  logic               rst;
  logic [VALUE_W-1:0] value;
  logic [DIGITS-1:0]  dot_pattern;
  logic               load_valid;
  logic               load_ready;
  logic [7:0]         segments;
  logic [DIGITS-1:0]  digit_disable;
  logic               overflow;

  int          errors = 0;
  int          checks = 0;
  int unsigned edges;
  int unsigned mv;
  logic [3:0]  mdots;
  logic [6:0]  pat_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  sevseg_scan_display #(
    .DIGITS      (DIGITS),
    .VALUE_W     (VALUE_W),
    .REFRESH_DIV (REF)
  ) dut (
    .sysclk        (sysclk),
    .rst           (rst),
    .value         (value),
    .dot_pattern   (dot_pattern),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .segments      (segments),
    .digit_disable (digit_disable),
    .overflow      (overflow)
  );

  always #5 sysclk = ~sysclk;

  // Clock edges since reset release; a scan slot starts every REF edges.
  always @(posedge sysclk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int unsigned v, input logic [3:0] dots,
                                         input int idx);
    int unsigned p;
    logic        dp;
    p  = 1;
    for (int k = 0; k < idx; k++) p = p * 10;
    dp = ~dots[idx];
    if (v >= LIMIT) return {dp, 7'b0111111};
`ifdef SEVSEG_BLANK_LEADING_ZEROS_EN
    if (idx > 0 && v < p) return {dp, 7'h7F};
`endif
    return {dp, pat_tbl[(v / p) % 10]};
  endfunction

  // Observe one full scan round, starting at the first slot after the next edge.
  task automatic slot_round(input string tag);
    int               idx;
    logic [DIGITS-1:0] dd;
    @(negedge sysclk);
    while (edges % REF != 0) @(negedge sysclk);
    for (int s = 0; s < DIGITS; s++) begin
      idx = (edges / REF) % DIGITS;
      dd  = ~(DIGITS'(1) << idx);
      check($sformatf("%s.dd%0d", tag, idx), 32'(digit_disable), 32'(dd));
      check($sformatf("%s.seg%0d", tag, idx), 32'(segments), 32'(exp_seg(mv, mdots, idx)));
      check($sformatf("%s.ovf%0d", tag, idx), 32'(overflow), 32'(mv >= LIMIT));
      repeat (REF) @(negedge sysclk);
    end
  endtask

  // Accept one load, optionally poke a competing load mid-conversion, and time the commit.
  task automatic do_load(input int unsigned v, input logic [3:0] d, input bit inject,
                         input int unsigned inj_v);
    int   n;
    logic old_ovf;
    old_ovf = (mv >= LIMIT);
    @(negedge sysclk);
    value       = VALUE_W'(v);
    dot_pattern = d;
    load_valid  = 1'b1;
    check("ready_before_load", 32'(load_ready), 32'd1);
    @(posedge sysclk);
    @(negedge sysclk);
    load_valid  = 1'b0;
    value       = VALUE_W'($urandom);
    dot_pattern = 4'($urandom);
    n = 0;
    while (load_ready !== 1'b1 && n < 40) begin
      if (n == VALUE_W) check("ovf_before_commit", 32'(overflow), 32'(old_ovf));
      if (inject && n == 2) begin
        value       = VALUE_W'(inj_v);
        dot_pattern = ~d;
        load_valid  = 1'b1;
      end
      if (inject && n == 6) load_valid = 1'b0;
      @(negedge sysclk);
      n++;
    end
    check("ready_low_cycles", 32'(n), 32'(VALUE_W + 1));
    mv    = v;
    mdots = d;
    check("ovf_after_commit", 32'(overflow), 32'(mv >= LIMIT));
  endtask

  initial begin
    int unsigned rv;
    rst         = 1'b1;
    value       = '0;
    dot_pattern = '0;
    load_valid  = 1'b0;
    mv          = 0;
    mdots       = '0;
    repeat (3) @(negedge sysclk);
    check("rst_seg", 32'(segments), 32'hFF);
    check("rst_dd", 32'(digit_disable), 32'hF);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd0);

    rst = 1'b0;
    #1;
    check("release_ready", 32'(load_ready), 32'd1);
    @(negedge sysclk);
    @(negedge sysclk);
    check("first_slot_dd", 32'(digit_disable), 32'hF);
    slot_round("zero_a");
    slot_round("zero_b");

    do_load(1234, 4'b0100, 1'b0, 0);
    slot_round("v1234");
    do_load(9999, 4'b0000, 1'b0, 0);
    slot_round("v9999");
    do_load(10000, 4'b1010, 1'b0, 0);
    slot_round("v10000");
    do_load(42, 4'b0001, 1'b0, 0);
    slot_round("v42");
    do_load(5, 4'b0011, 1'b1, 7);
    slot_round("ignore7");
    do_load(7, 4'b0000, 1'b0, 0);
    slot_round("v7");
    do_load(0, 4'b1000, 1'b0, 0);
    slot_round("v0");
    do_load(16383, 4'b1111, 1'b0, 0);
    slot_round("vmax");

    for (int i = 0; i < 6; i++) begin
      rv = $urandom_range(0, 16383);
      if (i % 2 == 0) rv = rv % 1000;
      do_load(rv, 4'($urandom), 1'b0, 0);
      slot_round($sformatf("rand%0d", i));
    end

    // Reset during the 6th conversion cycle aborts the load.
    @(negedge sysclk);
    value       = 14'd8888;
    dot_pattern = 4'b1111;
    load_valid  = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    load_valid = 1'b0;
    repeat (5) @(negedge sysclk);
    #2 rst = 1'b1;
    #1;
    check("midrst_seg", 32'(segments), 32'hFF);
    check("midrst_dd", 32'(digit_disable), 32'hF);
    check("midrst_ovf", 32'(overflow), 32'd0);
    check("midrst_ready", 32'(load_ready), 32'd0);
    repeat (2) @(negedge sysclk);
    rst   = 1'b0;
    mv    = 0;
    mdots = '0;
    #1;
    check("midrst_release_ready", 32'(load_ready), 32'd1);
    slot_round("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
